// File: rtl/duty_record_ctrl.sv
// -----------------------------------------------------------------------------
// duty_record_ctrl
//
// Record/playback sequencer for the X/Y duty-cycle sample memory.
//   IDLE   : live duty values are registered straight through to dc_x/dc_y.
//   RECORD : one RAM write per sample tick, starting at address 0.
//   PLAY   : one RAM read per sample tick; the returned sample drives dc_x/dc_y.
//
// The block owns all RAM addressing and strobes. The RAM itself is external
// and is never cleared here.
//
// Build option:
//   DUTY_LOOP_EN  defined   -> playback wraps at end-of-data and runs until stop/reset.
//                 undefined -> one-shot playback, back to IDLE after the last sample.
// -----------------------------------------------------------------------------
module duty_record_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 6,
    parameter int TICK_DIV = 50000
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic [DATA_W-1:0] duty_x_in,
    input  logic [DATA_W-1:0] duty_y_in,
    input  logic [DATA_W-1:0] mem_rdata_x,
    input  logic [DATA_W-1:0] mem_rdata_y,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata_x,
    output logic [DATA_W-1:0] mem_wdata_y,
    output logic [DATA_W-1:0] dc_x,
    output logic [DATA_W-1:0] dc_y,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   rec_len
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0]  TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    // Encoding is visible on the state port: 0 = IDLE, 1 = RECORD, 2 = PLAY.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e            state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] dc_x_q,    dc_x_d;
    logic [DATA_W-1:0] dc_y_q,    dc_y_d;

    // -------------------------------------------------------------------------
    // Derived strobes
    // -------------------------------------------------------------------------
    logic tick;
    logic wr_fire;
    logic rd_fire;
    logic last_sample;

    // The divider only runs outside IDLE, so tick never fires in IDLE.
    assign tick = (state_q != ST_IDLE) && (div_q == TICK_LAST);

    // A stop in the tick cycle suppresses that cycle's RAM access.
    assign wr_fire = (state_q == ST_RECORD) && tick && !stop && !reset;
    assign rd_fire = (state_q == ST_PLAY)   && tick && !stop && !reset;

    // True while the read address points at the final stored sample.
    assign last_sample = ({1'b0, rd_addr_q} + LEN_ONE) == rec_len_q;

    // -------------------------------------------------------------------------
    // Next-state decode: stop first, then start commands, then end conditions.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default on the
        // first line; a path that leaves it unassigned would infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop) begin
                    if (rec_start) begin
                        state_d = ST_RECORD;
                    end else if (play_start && (rec_len_q != '0)) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_RECORD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick && (wr_addr_q == ADDR_MAX)) begin
                    // Final address written this cycle: memory is full.
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end
`ifndef DUTY_LOOP_EN
                else if (rd_pend_q && last_sample) begin
                    // Last sample lands in dc at this edge; one-shot ends here.
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sample divider: counts 0..TICK_DIV-1, held at 0 in IDLE, restarts on
    // every state change so the first tick is a full period after entry.
    // -------------------------------------------------------------------------
    always_comb begin
        div_d = div_q + DIV_ONE;
        if ((state_d != state_q) || (state_q == ST_IDLE) || tick) begin
            div_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Record counters: cleared on entry, advanced by each accepted write.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_addr_d = wr_addr_q;
        rec_len_d = rec_len_q;
        if ((state_q == ST_IDLE) && (state_d == ST_RECORD)) begin
            wr_addr_d = '0;
            rec_len_d = '0;
        end else if (wr_fire) begin
            rec_len_d = rec_len_q + LEN_ONE;
            // The write address saturates; the full condition exits RECORD.
            if (wr_addr_q != ADDR_MAX) begin
                wr_addr_d = wr_addr_q + ADDR_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Playback counters: a read issued on tick is consumed one cycle later,
    // which is also when the read address advances.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_pend_d = 1'b0;
        if ((state_q == ST_IDLE) && (state_d == ST_PLAY)) begin
            rd_addr_d = '0;
        end else if ((state_q == ST_PLAY) && !stop) begin
            rd_pend_d = rd_fire;
            if (rd_pend_q) begin
`ifdef DUTY_LOOP_EN
                rd_addr_d = last_sample ? '0 : (rd_addr_q + ADDR_ONE);
`else
                rd_addr_d = rd_addr_q + ADDR_ONE;
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // PWM duty select: live pass-through except while playing, where the
    // last read sample is held; a stop drops straight back to live values.
    // -------------------------------------------------------------------------
    always_comb begin
        dc_x_d = duty_x_in;
        dc_y_d = duty_y_in;
        if ((state_q == ST_PLAY) && !stop) begin
            dc_x_d = dc_x_q;
            dc_y_d = dc_y_q;
            if (rd_pend_q) begin
                dc_x_d = mem_rdata_x;
                dc_y_d = mem_rdata_y;
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM address and write data: address is 0 unless a strobe is active.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_addr    = '0;
        mem_wdata_x = '0;
        mem_wdata_y = '0;
        if (wr_fire) begin
            mem_addr    = wr_addr_q;
            mem_wdata_x = duty_x_in;
            mem_wdata_y = duty_y_in;
        end else if (rd_fire) begin
            mem_addr = rd_addr_q;
        end
    end

    assign mem_we  = wr_fire;
    assign mem_re  = rd_fire;
    assign dc_x    = dc_x_q;
    assign dc_y    = dc_y_q;
    assign state   = state_q;
    assign rec_len = rec_len_q;

    // -------------------------------------------------------------------------
    // State register with synchronous reset; reset aborts any mode at once.
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge value of the others, independent of statement order.
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rec_len_q <= '0;
            rd_pend_q <= 1'b0;
            dc_x_q    <= '0;
            dc_y_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            rec_len_q <= rec_len_d;
            rd_pend_q <= rd_pend_d;
            dc_x_q    <= dc_x_d;
            dc_y_q    <= dc_y_d;
        end
    end

endmodule

// File: tb/tb_duty_record_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for duty_record_ctrl (ADDR_W = 2, TICK_DIV = 4).
// Random duty samples are driven at each sample tick; the bench keeps its own
// list of what it recorded and derives every expected write, read address and
// playback value from that list and the sample period.
// -----------------------------------------------------------------------------
module tb_duty_record_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 6;
    localparam int TD    = 4;
    localparam int DEPTH = 1 << AW;

    logic          sysclk     = 1'b0;
    logic          reset      = 1'b1;
    logic          rec_start  = 1'b0;
    logic          play_start = 1'b0;
    logic          stop       = 1'b0;
    logic [DW-1:0] duty_x_in  = '0;
    logic [DW-1:0] duty_y_in  = '0;
    logic [DW-1:0] mem_rdata_x;
    logic [DW-1:0] mem_rdata_y;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata_x;
    logic [DW-1:0] mem_wdata_y;
    logic [DW-1:0] dc_x;
    logic [DW-1:0] dc_y;
    logic [1:0]    state;
    logic [AW:0]   rec_len;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: samples the bench believes are stored, in order.
    logic [DW-1:0] exp_x[$];
    logic [DW-1:0] exp_y[$];

    // External RAM: synchronous write, read data valid the cycle after mem_re.
    logic [DW-1:0] ram_x [DEPTH];
    logic [DW-1:0] ram_y [DEPTH];

    always @(posedge sysclk) begin
        if (mem_we) begin
            ram_x[mem_addr] <= mem_wdata_x;
            ram_y[mem_addr] <= mem_wdata_y;
        end
        if (mem_re) begin
            mem_rdata_x <= ram_x[mem_addr];
            mem_rdata_y <= ram_y[mem_addr];
        end
    end

    always #5 sysclk = ~sysclk;

    duty_record_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .duty_x_in  (duty_x_in),
        .duty_y_in  (duty_y_in),
        .mem_rdata_x(mem_rdata_x),
        .mem_rdata_y(mem_rdata_y),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata_x(mem_wdata_x),
        .mem_wdata_y(mem_wdata_y),
        .dc_x       (dc_x),
        .dc_y       (dc_y),
        .state      (state),
        .rec_len    (rec_len)
    );

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive_live(output logic [DW-1:0] x, output logic [DW-1:0] y);
        x = DW'($urandom);
        y = DW'($urandom);
        duty_x_in = x;
        duty_y_in = y;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [DW-1:0] x, y;
        reset = 1'b1;
        drive_live(x, y);
        cyc();
        cyc();
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_tests++;
        if (rec_len !== '0) begin n_fail++; $display("FAIL reset_rec_len: got %0d expected 0", rec_len); end
        n_tests++;
        if ({dc_x, dc_y} !== '0) begin n_fail++; $display("FAIL reset_dc: got %0d/%0d expected 0/0", dc_x, dc_y); end
        n_tests++;
        if ({mem_we, mem_re, mem_addr} !== '0) begin
            n_fail++; $display("FAIL reset_mem: we=%0d re=%0d addr=%0d expected all 0", mem_we, mem_re, mem_addr);
        end
        reset = 1'b0;
        drive_live(x, y);
        cyc();
        n_tests++;
        if ({dc_x, dc_y} !== {x, y}) begin
            n_fail++; $display("FAIL idle_passthrough: got %0d/%0d expected %0d/%0d", dc_x, dc_y, x, y);
        end
    endtask

    // -------------------------------------------------------------------------
    // Record n samples. full=1: let memory fill; full=0: stop on the next tick.
    // -------------------------------------------------------------------------
    task automatic run_record(input int n, input bit full);
        logic [DW-1:0] x, y;
        exp_x.delete();
        exp_y.delete();
        rec_start = 1'b1;
        cyc();
        rec_start = 1'b0;
        n_tests++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL rec_enter_state: got %0d expected 1", state); end
        n_tests++;
        if (rec_len !== '0) begin n_fail++; $display("FAIL rec_enter_len: got %0d expected 0", rec_len); end
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < TD - 1; c++) begin
                drive_live(x, y);
                #1;
                n_tests++;
                if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rec_gap_we: got %0d expected 0 (tick %0d)", mem_we, t); end
                cyc();
                n_tests++;
                if ({dc_x, dc_y} !== {x, y}) begin
                    n_fail++; $display("FAIL rec_dc_track: got %0d/%0d expected %0d/%0d", dc_x, dc_y, x, y);
                end
            end
            drive_live(x, y);
            #1;
            n_tests++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(t)) begin
                n_fail++; $display("FAIL rec_write: we=%0d addr=%0d expected we=1 addr=%0d", mem_we, mem_addr, t);
            end
            n_tests++;
            if ({mem_wdata_x, mem_wdata_y} !== {x, y}) begin
                n_fail++; $display("FAIL rec_wdata: got %0d/%0d expected %0d/%0d", mem_wdata_x, mem_wdata_y, x, y);
            end
            exp_x.push_back(x);
            exp_y.push_back(y);
            cyc();
        end
        if (full) begin
            n_tests++;
            if (state !== 2'd0) begin n_fail++; $display("FAIL rec_full_idle: got %0d expected 0", state); end
            n_tests++;
            if (rec_len !== (AW + 1)'(n)) begin n_fail++; $display("FAIL rec_full_len: got %0d expected %0d", rec_len, n); end
            for (int c = 0; c < 2 * TD; c++) begin
                n_tests++;
                if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rec_no_extra_write: got we=%0d expected 0", mem_we); end
                cyc();
            end
        end else begin
            for (int c = 0; c < TD - 1; c++) cyc();
            stop = 1'b1;
            #1;
            n_tests++;
            if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rec_stop_suppress: got we=%0d expected 0", mem_we); end
            cyc();
            stop = 1'b0;
            n_tests++;
            if (state !== 2'd0) begin n_fail++; $display("FAIL rec_stop_idle: got %0d expected 0", state); end
            n_tests++;
            if (rec_len !== (AW + 1)'(n)) begin n_fail++; $display("FAIL rec_stop_len: got %0d expected %0d", rec_len, n); end
        end
    endtask

    // -------------------------------------------------------------------------
    // Play back the recorded list. Loop build reads two extra samples past the
    // end and then stops while a read is in flight.
    // -------------------------------------------------------------------------
    task automatic run_play();
        int len;
        int nreads;
        int k;
        logic [DW-1:0] hx, hy, x, y, wx, wy;
        len = exp_x.size();
`ifdef DUTY_LOOP_EN
        nreads = len + 2;
`else
        nreads = len;
`endif
        drive_live(hx, hy);
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        n_tests++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL play_enter_state: got %0d expected 2", state); end
        for (int t = 0; t < nreads; t++) begin
            for (int c = 0; c < TD - 1; c++) begin
                drive_live(x, y);
                #1;
                n_tests++;
                if (mem_re !== 1'b0) begin n_fail++; $display("FAIL play_gap_re: got %0d expected 0", mem_re); end
                if (t == 0 || c >= 1) begin
                    if (t == 0) begin
                        wx = hx; wy = hy;
                    end else begin
                        k = (t - 1) % len;
                        wx = exp_x[k]; wy = exp_y[k];
                    end
                    n_tests++;
                    if ({dc_x, dc_y} !== {wx, wy}) begin
                        n_fail++; $display("FAIL play_dc: got %0d/%0d expected %0d/%0d (read %0d)", dc_x, dc_y, wx, wy, t);
                    end
                end
                cyc();
            end
            n_tests++;
            if (mem_re !== 1'b1 || mem_addr !== AW'(t % len)) begin
                n_fail++; $display("FAIL play_read: re=%0d addr=%0d expected re=1 addr=%0d", mem_re, mem_addr, t % len);
            end
            cyc();
        end
        k = (nreads - 1) % len;
`ifdef DUTY_LOOP_EN
        // Live value chosen to differ from the in-flight sample.
        x = exp_x[k] ^ DW'(1);
        y = exp_y[k] ^ DW'(1);
        duty_x_in = x;
        duty_y_in = y;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL play_stop_idle: got %0d expected 0", state); end
        n_tests++;
        if ({dc_x, dc_y} !== {x, y}) begin
            n_fail++; $display("FAIL play_stop_discard: got %0d/%0d expected %0d/%0d", dc_x, dc_y, x, y);
        end
`else
        x = exp_x[k] ^ DW'(1);
        y = exp_y[k] ^ DW'(1);
        duty_x_in = x;
        duty_y_in = y;
        #1;
        n_tests++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL play_last_state: got %0d expected 2", state); end
        cyc();
        n_tests++;
        if ({dc_x, dc_y} !== {exp_x[k], exp_y[k]}) begin
            n_fail++; $display("FAIL play_last_dc: got %0d/%0d expected %0d/%0d", dc_x, dc_y, exp_x[k], exp_y[k]);
        end
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL play_oneshot_idle: got %0d expected 0", state); end
        cyc();
        n_tests++;
        if ({dc_x, dc_y} !== {x, y}) begin
            n_fail++; $display("FAIL play_live_resume: got %0d/%0d expected %0d/%0d", dc_x, dc_y, x, y);
        end
`endif
    endtask

    // -------------------------------------------------------------------------
    task automatic test_priority();
        int len;
        len = exp_x.size();
        // stop together with start commands keeps IDLE and leaves the recording.
        stop = 1'b1; rec_start = 1'b1; play_start = 1'b1;
        cyc();
        stop = 1'b0; rec_start = 1'b0; play_start = 1'b0;
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL prio_stop_wins: got %0d expected 0", state); end
        n_tests++;
        if (rec_len !== (AW + 1)'(len)) begin n_fail++; $display("FAIL prio_stop_len: got %0d expected %0d", rec_len, len); end
        // rec_start beats play_start.
        rec_start = 1'b1; play_start = 1'b1;
        cyc();
        rec_start = 1'b0; play_start = 1'b0;
        n_tests++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL prio_rec_over_play: got %0d expected 1", state); end
        n_tests++;
        if (rec_len !== '0) begin n_fail++; $display("FAIL prio_rec_clears_len: got %0d expected 0", rec_len); end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        exp_x.delete();
        exp_y.delete();
        n_tests++;
        if (state !== 2'd0 || rec_len !== '0) begin
            n_fail++; $display("FAIL prio_empty_stop: state=%0d len=%0d expected 0/0", state, rec_len);
        end
        // play_start with nothing recorded is ignored.
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        for (int c = 0; c < TD + 1; c++) begin
            n_tests++;
            if (state !== 2'd0 || mem_re !== 1'b0) begin
                n_fail++; $display("FAIL guard_play_empty: state=%0d re=%0d expected 0/0", state, mem_re);
            end
            cyc();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_play();
        logic [DW-1:0] x, y;
        run_record(2, 1'b0);
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        rec_start = 1'b1;
        cyc();
        rec_start = 1'b0;
        n_tests++;
        if (state !== 2'd2 || rec_len !== (AW + 1)'(2)) begin
            n_fail++; $display("FAIL play_ignores_rec: state=%0d len=%0d expected 2/2", state, rec_len);
        end
        cyc();
        cyc();
        n_tests++;
        if (mem_re !== 1'b1 || mem_addr !== '0) begin
            n_fail++; $display("FAIL midplay_read: re=%0d addr=%0d expected 1/0", mem_re, mem_addr);
        end
        cyc();
        x = DW'($urandom_range(1, (1 << DW) - 1));
        y = DW'($urandom_range(1, (1 << DW) - 1));
        duty_x_in = x;
        duty_y_in = y;
        reset = 1'b1;
        cyc();
        n_tests++;
        if (state !== 2'd0 || rec_len !== '0) begin
            n_fail++; $display("FAIL midplay_reset_state: state=%0d len=%0d expected 0/0", state, rec_len);
        end
        n_tests++;
        if ({dc_x, dc_y, mem_we, mem_re, mem_addr, mem_wdata_x, mem_wdata_y} !== '0) begin
            n_fail++; $display("FAIL midplay_reset_outputs: dc=%0d/%0d we=%0d re=%0d addr=%0d expected all 0",
                               dc_x, dc_y, mem_we, mem_re, mem_addr);
        end
        reset = 1'b0;
        cyc();
        n_tests++;
        if ({dc_x, dc_y} !== {x, y}) begin
            n_fail++; $display("FAIL post_reset_passthrough: got %0d/%0d expected %0d/%0d", dc_x, dc_y, x, y);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        run_record(3, 1'b0);   // record then stop on the 4th tick
        run_play();            // 3-sample playback
        run_record(DEPTH, 1'b1);
        run_play();            // full-depth playback
        test_priority();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/duty_record_ctrl.md
# duty_record_ctrl

Sequencer for the X/Y duty-cycle sample memory: records live `Duty_X`/`Duty_Y` values into an external dual-array RAM at a fixed sample rate, then plays them back to the PWM stage, either once or looped. It sits between the joystick/duty generators and the PWM drivers and owns all RAM address and write-enable generation. In idle it passes live duty values straight through.

## Interface
- `ADDR_W`, 8: RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 6: duty sample width.
- `TICK_DIV`, 50000: sysclk cycles per sample period; must be at least 2.
- `sysclk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rec_start` in 1: one-cycle pulse; begin recording.
- `play_start` in 1: one-cycle pulse; begin playback.
- `stop` in 1: one-cycle pulse; abort the current mode.
- `duty_x_in`, `duty_y_in` in DATA_W: live duty values.
- `mem_rdata_x`, `mem_rdata_y` in DATA_W: RAM read data, valid 1 cycle after `mem_re`.
- `mem_addr` out ADDR_W: RAM address.
- `mem_we` out 1: RAM write strobe.
- `mem_re` out 1: RAM read strobe.
- `mem_wdata_x`, `mem_wdata_y` out DATA_W: RAM write data.
- `dc_x`, `dc_y` out DATA_W: duty values to PWM.
- `state` out 2: 0 = IDLE, 1 = RECORD, 2 = PLAY.
- `rec_len` out ADDR_W+1: number of stored samples.

## Operation
- **Reset.** All outputs are 0. `state` = IDLE, `rec_len` = 0, and all counters are 0. RAM contents are not touched. Reset mid-record or mid-play aborts immediately.
- **Sample divider.**
  - The divider counts 0..TICK_DIV-1 and wraps.
  - `tick` is high when the divider equals TICK_DIV-1.
  - The divider is cleared on every state change.
- **Command priority.**
  - `stop` beats everything else.
  - In IDLE, `rec_start` beats `play_start`.
  - Start pulses outside IDLE are ignored.
  - `play_start` is ignored when `rec_len` = 0.
- **IDLE.**
  - `dc_x`/`dc_y` take `duty_x_in`/`duty_y_in` registered, so they lag by 1 cycle.
  - `mem_we` = `mem_re` = 0.
- **RECORD.**
  - Entry clears `wr_addr` and `rec_len`.
  - On each `tick`: `mem_we` = 1, `mem_addr` = `wr_addr`, and `mem_wdata` = the live inputs in that same cycle. Then `wr_addr` and `rec_len` increment.
  - `dc` keeps tracking the live inputs.
  - The write at address 2^ADDR_W-1 (memory full) sets `rec_len` = 2^ADDR_W and returns to IDLE on the next edge. The address never wraps.
  - `stop` returns to IDLE. `rec_len` keeps the count already written; a `stop` coinciding with a `tick` suppresses that write.
- **PLAY.**
  - Entry clears `rd_addr`.
  - On each `tick`: `mem_re` = 1 and `mem_addr` = `rd_addr`.
  - On the next cycle, `dc_x`/`dc_y` load `mem_rdata` at the closing edge, and `rd_addr` increments.
  - Between ticks, `dc` holds its last sample.
  - When `rd_addr` reaches `rec_len` it is end-of-data; behaviour there depends on the Configuration macro.
  - `stop` returns to IDLE at once. A read already in flight is discarded, and `dc` resumes live pass-through.
- **Other modes.** `mem_addr` is 0 outside RECORD/PLAY strobes. `mem_wdata` is a don't-care when `mem_we` = 0.

## Timing
- A start pulse sampled at edge N gives `state` changed after edge N and divider = 0.
- The first `tick` occurs TICK_DIV cycles after entry. Successive ticks are TICK_DIV cycles apart.
- Record latency: the write happens in the tick cycle itself.
- Playback latency: `dc` updates 2 edges after the tick cycle begins, i.e. visible in the cycle after the `mem_re` cycle + 1.
- End-of-record return to IDLE is 1 cycle after the final write.
- `stop` acts at the next edge.

## Configuration
- `DUTY_LOOP_EN` defined: at end-of-data, `rd_addr` wraps to 0 and PLAY continues indefinitely until `stop` or `reset`.
- `DUTY_LOOP_EN` undefined: after the last sample is loaded into `dc`, the block returns to IDLE (one-shot). `dc` reverts to live pass-through 1 cycle later.

## Test plan
All scenarios use ADDR_W = 2 and TICK_DIV = 4.
- **Record then stop.** Reset, then `rec_start`. Drive x = 5,6,7 on successive ticks, then `stop` before the 4th tick. Expect `mem_we` pulses at addresses 0,1,2 with data 5,6,7, `rec_len` = 3, and `state` = IDLE.
- **Full record.** Record without `stop`. Expect 4 writes at addresses 0..3, then IDLE one cycle after the 4th write, with `rec_len` = 4 and no 5th write.
- **One-shot play** (`DUTY_LOOP_EN` undefined). After the 3-sample record, `play_start`. Expect `mem_re` at addresses 0,1,2 every 4 cycles and `dc_x` = 5,6,7, each appearing 2 edges after its tick. Then IDLE, and `dc_x` follows live input.
- **Loop play** (`DUTY_LOOP_EN` defined). Same stimulus. Expect read address sequence 0,1,2,0,1 and `dc_x` = 5,6,7,5,6. `stop` returns to IDLE.
- **Priority and guards.**
  - `rec_start` + `play_start` in the same cycle enters RECORD.
  - `stop` + `rec_start` stays IDLE.
  - `play_start` with `rec_len` = 0 stays IDLE.
  - `rec_start` during PLAY is ignored.
- **Reset mid-operation.** Assert `reset` during PLAY. Next cycle all outputs are 0, `rec_len` = 0, and `state` = IDLE.
